// File: rtl/event_unit_pkg.sv
// ---------------------------------------------------------------------------
// event_unit_pkg : register map, state encoding and sizes for the event unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package event_unit_pkg;

  localparam int EU_NB_EVT = 32;

  localparam logic [7:0] EU_MASK_OFS           = 8'h00;
  localparam logic [7:0] EU_MASK_AND_OFS       = 8'h04;
  localparam logic [7:0] EU_MASK_OR_OFS        = 8'h08;
  localparam logic [7:0] EU_BUFFER_OFS         = 8'h0C;
  localparam logic [7:0] EU_BUFFER_MASKED_OFS  = 8'h10;
  localparam logic [7:0] EU_BUFFER_CLEAR_OFS   = 8'h14;
  localparam logic [7:0] EU_EVT_WAIT_OFS       = 8'h18;
  localparam logic [7:0] EU_EVT_WAIT_CLEAR_OFS = 8'h1C;
  localparam logic [7:0] EU_IRQ_MASK_OFS       = 8'h20;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } eu_core_state_e;

endpackage

`default_nettype wire

// File: rtl/event_unit_core_if.sv
// ---------------------------------------------------------------------------
// event_unit_core_if : core peripheral request/response port of the event unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface event_unit_core_if #(
  parameter int ADDR_W = 8
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [31:0]       wdata;
  logic              gnt;
  logic              r_valid;
  logic [31:0]       r_rdata;
  logic              r_opc;

  modport master (
    output req, addr, we, wdata,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, addr, we, wdata,
    output gnt, r_valid, r_rdata, r_opc
  );

endinterface

`default_nettype wire

// File: rtl/eu_prio_enc.sv
// ---------------------------------------------------------------------------
// eu_prio_enc : lowest-set-bit index encoder with valid flag.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module eu_prio_enc #(
  parameter  int NB    = 32,
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [NB-1:0]    vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx_o = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |vec_i;

endmodule

`default_nettype wire

// File: rtl/event_unit_core.sv
// ---------------------------------------------------------------------------
// event_unit_core : per-core sticky event buffer, software mask and blocking
// wait-for-event with core clock gating. Optional IRQ block: EU_CORE_IRQ_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module event_unit_core
  import event_unit_pkg::*;
#(
  parameter int NB_EVT = EU_NB_EVT,
  parameter int ADDR_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NB_EVT-1:0]         events_i,
  event_unit_core_if.slave          periph,
`ifdef EU_CORE_IRQ_EN
  output logic                      irq_req_o,
  output logic [$clog2(NB_EVT)-1:0] irq_id_o,
  input  logic                      irq_ack_i,
`endif
  output logic                      core_clk_en_o
);

  localparam logic [1:0] ST_ACTIVE = 2'(ACTIVE);
  localparam logic [1:0] ST_SLEEP  = 2'(SLEEP);
  localparam logic [1:0] ST_WAKE   = 2'(WAKE);

  logic [1:0]        state_q, state_d;
  logic [NB_EVT-1:0] mask_q, mask_d, buf_q, buf_d, clr, masked;
  logic              r_valid_q, r_valid_d, r_opc_q, r_opc_d;
  logic              resp_clr_q, resp_clr_d;
  logic [31:0]       r_rdata_q, r_rdata_d;

  logic [ADDR_W-1:0] ofs;
  logic              acc, rd_ok, wr_ok, err, wr_fire;
  logic              is_wait, is_wait_clr, go_sleep, wake, irq_pend;
  logic [NB_EVT-1:0] rd_val, wdata_evt;

`ifdef EU_CORE_IRQ_EN
  logic [NB_EVT-1:0] irq_mask_q, irq_mask_d, irq_vec;
`endif

  assign ofs       = {periph.addr[ADDR_W-1:2], 2'b00};
  assign masked    = buf_q & mask_q;
  assign wdata_evt = NB_EVT'(periph.wdata);
  assign acc       = (state_q == ST_ACTIVE) && periph.req;
  assign err       = periph.we ? !wr_ok : !rd_ok;
  assign wr_fire   = acc && periph.we && wr_ok;
  assign go_sleep  = acc && !periph.we && is_wait && rd_ok && (masked == '0);

  always_comb begin
    rd_ok       = 1'b0;
    wr_ok       = 1'b0;
    rd_val      = '0;
    is_wait     = 1'b0;
    is_wait_clr = 1'b0;
    case (ofs)
      ADDR_W'(EU_MASK_OFS): begin
        rd_ok  = 1'b1;
        wr_ok  = 1'b1;
        rd_val = mask_q;
      end
      ADDR_W'(EU_MASK_AND_OFS),
      ADDR_W'(EU_MASK_OR_OFS),
      ADDR_W'(EU_BUFFER_CLEAR_OFS): wr_ok = 1'b1;
      ADDR_W'(EU_BUFFER_OFS): begin
        rd_ok  = 1'b1;
        rd_val = buf_q;
      end
      ADDR_W'(EU_BUFFER_MASKED_OFS): begin
        rd_ok  = 1'b1;
        rd_val = masked;
      end
      // An empty mask could never wake the core, so a wait is refused.
      ADDR_W'(EU_EVT_WAIT_OFS): begin
        rd_ok   = (mask_q != '0);
        rd_val  = masked;
        is_wait = 1'b1;
      end
      ADDR_W'(EU_EVT_WAIT_CLEAR_OFS): begin
        rd_ok       = (mask_q != '0);
        rd_val      = masked;
        is_wait     = 1'b1;
        is_wait_clr = 1'b1;
      end
`ifdef EU_CORE_IRQ_EN
      ADDR_W'(EU_IRQ_MASK_OFS): begin
        rd_ok  = 1'b1;
        wr_ok  = 1'b1;
        rd_val = irq_mask_q;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    clr = '0;
    if (r_valid_q && resp_clr_q) clr = r_rdata_q[NB_EVT-1:0];
    if (wr_fire && (ofs == ADDR_W'(EU_BUFFER_CLEAR_OFS))) clr = clr | wdata_evt;
`ifdef EU_CORE_IRQ_EN
    if (irq_ack_i && irq_pend) clr[irq_id_o] = 1'b1;
`endif
  end

  // Set wins over clear so an event arriving with its clear is not lost.
  assign buf_d = (buf_q & ~clr) | events_i;
  assign wake  = |(buf_d & mask_q);

  assign core_clk_en_o = (state_q != ST_SLEEP) || wake || irq_pend;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    r_valid_d  = 1'b0;
    r_opc_d    = 1'b0;
    r_rdata_d  = '0;
    resp_clr_d = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (go_sleep) begin
          state_d    = ST_SLEEP;
          resp_clr_d = is_wait_clr;
        end else if (acc) begin
          r_valid_d = 1'b1;
          if (err) begin
            r_opc_d = 1'b1;
          end else if (!periph.we) begin
            r_rdata_d  = 32'(rd_val);
            resp_clr_d = is_wait_clr;
          end
        end
        if (wr_fire) begin
          case (ofs)
            ADDR_W'(EU_MASK_OFS):     mask_d = wdata_evt;
            ADDR_W'(EU_MASK_AND_OFS): mask_d = mask_q & ~wdata_evt;
            ADDR_W'(EU_MASK_OR_OFS):  mask_d = mask_q | wdata_evt;
            default: ;
          endcase
        end
      end
      ST_SLEEP: begin
        resp_clr_d = resp_clr_q;
        if (wake) begin
          state_d   = ST_WAKE;
          r_valid_d = 1'b1;
          r_rdata_d = 32'(buf_d & mask_q);
        end
      end
      ST_WAKE:  state_d = ST_ACTIVE;
      default:  state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_ACTIVE;
      mask_q     <= '0;
      buf_q      <= '0;
      r_valid_q  <= 1'b0;
      r_opc_q    <= 1'b0;
      r_rdata_q  <= '0;
      resp_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      buf_q      <= buf_d;
      r_valid_q  <= r_valid_d;
      r_opc_q    <= r_opc_d;
      r_rdata_q  <= r_rdata_d;
      resp_clr_q <= resp_clr_d;
    end
  end

  assign periph.gnt     = acc;
  assign periph.r_valid = r_valid_q;
  assign periph.r_opc   = r_opc_q;
  assign periph.r_rdata = r_rdata_q;

`ifdef EU_CORE_IRQ_EN
  assign irq_vec    = buf_q & irq_mask_q;
  assign irq_mask_d = (wr_fire && (ofs == ADDR_W'(EU_IRQ_MASK_OFS))) ? wdata_evt : irq_mask_q;
  assign irq_req_o  = irq_pend;

  eu_prio_enc #(
    .NB (NB_EVT)
  ) u_prio_enc (
    .vec_i   (irq_vec),
    .idx_o   (irq_id_o),
    .valid_o (irq_pend)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_mask_q <= '0;
    else         irq_mask_q <= irq_mask_d;
  end
`else
  assign irq_pend = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_event_unit_core.sv
// ---------------------------------------------------------------------------
// tb_event_unit_core : directed + randomized bench with a reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_event_unit_core;

`ifdef EU_CORE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] events = '0;
  logic        clk_en;
`ifdef EU_CORE_IRQ_EN
  logic        irq_req;
  logic [4:0]  irq_id;
  logic        irq_ack = 1'b0;
`endif

  event_unit_core_if #(.ADDR_W(8)) bus ();

  event_unit_core #(
    .NB_EVT (32),
    .ADDR_W (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .events_i      (events),
    .periph        (bus),
`ifdef EU_CORE_IRQ_EN
    .irq_req_o     (irq_req),
    .irq_id_o      (irq_id),
    .irq_ack_i     (irq_ack),
`endif
    .core_clk_en_o (clk_en)
  );

  always #5 clk = ~clk;

  // Reference model state: what software would see in the registers.
  logic [31:0] m_mask = '0, m_buf = '0, m_irq_mask = '0;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  function automatic void model_resp(input logic we, input logic [7:0] a,
                                     output logic err, output logic [31:0] rd, output bit slp);
    logic [7:0] o;
    bit rok, wok;
    o = a & 8'hFC; rok = 0; wok = 0; rd = '0; slp = 0;
    case (o)
      8'h00: begin rok = 1; wok = 1; rd = m_mask; end
      8'h04, 8'h08, 8'h14: wok = 1;
      8'h0C: begin rok = 1; rd = m_buf; end
      8'h10: begin rok = 1; rd = m_buf & m_mask; end
      8'h18, 8'h1C: begin
        rok = (m_mask != 0);
        rd  = m_buf & m_mask;
        slp = !we && rok && (rd == 0);
      end
      8'h20: if (IRQ_EN) begin rok = 1; wok = 1; rd = m_irq_mask; end
      default: ;
    endcase
    err = we ? !wok : !rok;
    if (err || we) rd = '0;
  endfunction

  // Starts #1 after a rising edge; returns #1 after a rising edge, or at the
  // falling edge of the first sleep cycle when wev == 0.
  task automatic access(input logic we, input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] ev, input int idle, input logic [31:0] wev);
    logic        e_err;
    logic [31:0] e_rd, u;
    bit          e_slp;
    logic [7:0]  o;
    o = a & 8'hFC;
    model_resp(we, a, e_err, e_rd, e_slp);
    bus.req = 1'b1; bus.we = we; bus.addr = a; bus.wdata = wd; events = ev;
    @(negedge clk);
    chk("gnt", 32'(bus.gnt), 32'd1);
    chk("rvalid_grant_cycle", 32'(bus.r_valid), 32'd0);
    @(posedge clk); #1;
    bus.req = 1'b0; events = '0;
    if (we && !e_err) begin
      case (o)
        8'h00: m_mask = wd;
        8'h04: m_mask = m_mask & ~wd;
        8'h08: m_mask = m_mask | wd;
        8'h14: m_buf  = m_buf & ~wd;
        8'h20: m_irq_mask = wd;
        default: ;
      endcase
    end
    m_buf = m_buf | ev;
    if (!e_slp) begin
      @(negedge clk);
      chk("rvalid", 32'(bus.r_valid), 32'd1);
      chk("opc", 32'(bus.r_opc), 32'(e_err));
      chk("rdata", bus.r_rdata, e_rd);
      chk("clk_en_active", 32'(clk_en), 32'd1);
      @(posedge clk); #1;
      if (o == 8'h1C && !e_err) m_buf = m_buf & ~e_rd;
    end else begin
      @(negedge clk);
      chk("clk_en_sleep", 32'(clk_en), 32'((m_buf & m_irq_mask) != 0));
      chk("no_rvalid_sleep", 32'(bus.r_valid), 32'd0);
      if (wev == 0) return;
      for (int i = 0; i < idle; i++) begin
        @(posedge clk); #1;
        u = $urandom & $urandom & ~m_mask;
        events = u;
        @(negedge clk);
        chk("clk_en_idle", 32'(clk_en), 32'((m_buf & m_irq_mask) != 0));
        chk("no_rvalid_idle", 32'(bus.r_valid), 32'd0);
        m_buf = m_buf | u;
      end
      @(posedge clk); #1;
      events = wev;
      @(negedge clk);
      chk("clk_en_wake", 32'(clk_en), 32'd1);
      @(posedge clk); #1;
      events = '0;
      m_buf = m_buf | wev;
      e_rd = m_buf & m_mask;
      @(negedge clk);
      chk("wake_rvalid", 32'(bus.r_valid), 32'd1);
      chk("wake_opc", 32'(bus.r_opc), 32'd0);
      chk("wake_rdata", bus.r_rdata, e_rd);
      @(posedge clk); #1;
      if (o == 8'h1C) m_buf = m_buf & ~e_rd;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    access(1'b1, a, d, '0, 0, 32'd1);
  endtask

  task automatic rd(input logic [7:0] a);
    access(1'b0, a, '0, '0, 0, 32'd1);
  endtask

  task automatic pulse(input logic [31:0] v);
    events = v;
    @(posedge clk); #1;
    events = '0;
    m_buf = m_buf | v;
  endtask

  function automatic logic [31:0] wake_ev();
    return (m_mask & (~m_mask + 32'd1)) | ($urandom & $urandom & ~m_mask);
  endfunction

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clk_en", 32'(clk_en), 32'd1);
    chk("rst_rvalid", 32'(bus.r_valid), 32'd0);
    chk("rst_opc", 32'(bus.r_opc), 32'd0);
    chk("rst_rdata", bus.r_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd(8'h00);
    rd(8'h0C);

    wr(8'h00, 32'h0000_0104);
    pulse(32'h0000_0100);
    rd(8'h10);
    access(1'b1, 8'h14, 32'h100, 32'h100, 0, 32'd1);
    rd(8'h0C);
    chk("set_wins", m_buf, 32'h100);

    wr(8'h14, 32'hFFFF_FFFF);
    wr(8'h00, 32'h1);
    access(1'b0, 8'h1C, '0, '0, 10, 32'h1);
    rd(8'h0C);

    wr(8'h00, 32'h0);
    rd(8'h18);
    wr(8'h0C, 32'h5);
    rd(8'h3C);
    rd(8'h21);
    wr(8'h04, 32'h0);
    rd(8'h08);

    // Reset while the core is asleep.
    wr(8'h00, 32'h2);
    wr(8'h14, 32'hFFFF_FFFF);
    access(1'b0, 8'h18, '0, '0, 0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("sleep_rst_clk_en", 32'(clk_en), 32'd1);
    chk("sleep_rst_rvalid", 32'(bus.r_valid), 32'd0);
    @(posedge clk); #1;
    chk("sleep_rst_rvalid2", 32'(bus.r_valid), 32'd0);
    m_mask = '0; m_buf = '0; m_irq_mask = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd(8'h00);

`ifdef EU_CORE_IRQ_EN
    wr(8'h20, 32'h30);
    pulse(32'h20);
    @(negedge clk);
    chk("irq_req", 32'(irq_req), 32'd1);
    chk("irq_id", 32'(irq_id), 32'd5);
    @(posedge clk); #1;
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
    m_buf = m_buf & ~32'h20;
    @(negedge clk);
    chk("irq_req_after_ack", 32'(irq_req), 32'd0);
    @(posedge clk); #1;
    rd(8'h0C);
    wr(8'h20, 32'h0);
`endif

    for (int n = 0; n < 200; n++) begin
      logic [31:0] r;
      r = $urandom & $urandom;
      case ($urandom_range(0, 10))
        0: wr(8'h00, ($urandom_range(0, 3) == 0) ? 32'h0 : r);
        1: wr(8'h04, r);
        2: wr(8'h08, r);
        3: rd(8'h00);
        4: rd(8'h0C);
        5: rd(8'h10);
        6: access(1'b1, 8'h14, $urandom, $urandom & $urandom & $urandom, 0, 32'd1);
        7: pulse(r & $urandom);
        8: access(1'b0, 8'h18, '0, '0, $urandom_range(0, 4), wake_ev());
        9: access(1'b0, 8'h1C, '0, '0, $urandom_range(0, 4), wake_ev());
        default: access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), r, '0,
                        $urandom_range(0, 3), wake_ev());
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
